// File: rtl/ra_guard_stack.sv
// Return-address guard: a circular shadow stack of encoded links, checked on every return.
// Optional crash request on mismatch is compiled in with RA_GUARD_CRASH_EN.
module ra_guard_stack #(
  parameter int unsigned DEPTH = 8,
  parameter logic [30:0] KEY   = 31'h73fa06c2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     call_valid_i,
  input  logic [31:0]              call_link_i,
  input  logic                     ret_valid_i,
  input  logic [31:0]              ret_link_i,
  input  logic                     clear_i,
  input  logic                     en_crash_i,
  output logic [31:0]              ret_pc_o,
  output logic                     ret_pc_valid_o,
  output logic                     mismatch_o,
  output logic                     to_crash_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic [15:0]              mismatch_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [30:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] ptr_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [30:0]   top_entry;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          ovf_set;
  logic          mis_c;
  logic          unused_bits;

  assign unused_bits = ^{call_link_i[31], ret_link_i[31], ret_link_i[0]};

  // Next pointer/occupancy: a same-cycle pop and push rewrites the top slot in place.
  always_comb begin
    top_idx   = wr_ptr - PW'(1);
    top_entry = mem[top_idx];
    empty     = (depth_o == '0);
    full      = (depth_o == CW'(DEPTH));
    do_pop    = ret_valid_i && !empty;
    mis_c     = 1'b0;
    if (ret_valid_i) begin
      mis_c = empty ? !overflow_o : (top_entry[30:1] != ret_link_i[30:1]);
    end
    wr_addr = do_pop ? top_idx : wr_ptr;
    ptr_nxt = wr_ptr;
    cnt_nxt = depth_o;
    ovf_set = 1'b0;
    if (call_valid_i && !do_pop) begin
      ptr_nxt = wr_ptr + PW'(1);
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        cnt_nxt = depth_o + CW'(1);
      end
    end else if (do_pop && !call_valid_i) begin
      ptr_nxt = wr_ptr - PW'(1);
      cnt_nxt = depth_o - CW'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (call_valid_i && !clear_i) begin
      mem[wr_addr] <= call_link_i[30:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr         <= '0;
      depth_o        <= '0;
      overflow_o     <= 1'b0;
      ret_pc_o       <= '0;
      ret_pc_valid_o <= 1'b0;
      mismatch_o     <= 1'b0;
      mismatch_cnt_o <= '0;
    end else if (clear_i) begin
      wr_ptr         <= '0;
      depth_o        <= '0;
      overflow_o     <= 1'b0;
      ret_pc_o       <= '0;
      ret_pc_valid_o <= 1'b0;
      mismatch_o     <= 1'b0;
      mismatch_cnt_o <= '0;
    end else begin
      wr_ptr         <= ptr_nxt;
      depth_o        <= cnt_nxt;
      overflow_o     <= overflow_o | ovf_set;
      ret_pc_o       <= do_pop ? {1'b1, top_entry ^ KEY} : 32'h0;
      ret_pc_valid_o <= do_pop;
      mismatch_o     <= mis_c;
      if (mis_c && (mismatch_cnt_o != 16'hFFFF)) begin
        mismatch_cnt_o <= mismatch_cnt_o + 16'd1;
      end
    end
  end

`ifdef RA_GUARD_CRASH_EN
  // Sticky crash request, raised alongside the mismatch pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_crash_o <= 1'b0;
    end else if (clear_i) begin
      to_crash_o <= 1'b0;
    end else if (mis_c && en_crash_i) begin
      to_crash_o <= 1'b1;
    end
  end
`else
  logic unused_crash;
  assign unused_crash = en_crash_i;
  assign to_crash_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ra_guard_stack.sv
// Self-checking bench for ra_guard_stack: directed scenarios plus randomized traffic vs. a queue model.
module tb_ra_guard_stack;

  localparam int unsigned DEPTH = 8;
  localparam logic [30:0] KEY   = 31'h73fa06c2;
`ifdef RA_GUARD_CRASH_EN
  localparam bit CRASH_EN = 1'b1;
`else
  localparam bit CRASH_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        call_valid_i, ret_valid_i, clear_i, en_crash_i;
  logic [31:0] call_link_i, ret_link_i;
  logic [31:0] ret_pc_o;
  logic        ret_pc_valid_o, mismatch_o, to_crash_o, overflow_o;
  logic [3:0]  depth_o;
  logic [15:0] mismatch_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] q[$];
  logic        m_ovf, m_crash, e_valid, e_mis;
  logic [31:0] e_pc;
  logic [15:0] m_cnt;

  ra_guard_stack #(.DEPTH(DEPTH), .KEY(KEY)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .call_valid_i(call_valid_i), .call_link_i(call_link_i),
    .ret_valid_i(ret_valid_i), .ret_link_i(ret_link_i),
    .clear_i(clear_i), .en_crash_i(en_crash_i),
    .ret_pc_o(ret_pc_o), .ret_pc_valid_o(ret_pc_valid_o),
    .mismatch_o(mismatch_o), .to_crash_o(to_crash_o),
    .overflow_o(overflow_o), .depth_o(depth_o),
    .mismatch_cnt_o(mismatch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_crash = 0; m_cnt = 0;
    e_valid = 0; e_mis = 0; e_pc = 0;
  endtask

  // Drive one cycle, advance the model on the edge, return 1ns after it.
  task automatic cycle(input logic call, input logic [31:0] cl,
                       input logic ret, input logic [31:0] rl, input logic clr);
    logic [31:0] e;
    call_valid_i = call; call_link_i = cl;
    ret_valid_i = ret; ret_link_i = rl; clear_i = clr;
    @(posedge clk_i);
    e_valid = 0; e_pc = 0; e_mis = 0;
    if (clr) begin
      q.delete(); m_ovf = 0; m_crash = 0; m_cnt = 0;
    end else begin
      if (ret) begin
        if (q.size() > 0) begin
          e = q.pop_back();
          e_valid = 1;
          e_pc = {1'b1, e[30:0] ^ KEY};
          e_mis = (e[30:1] != rl[30:1]);
        end else begin
          e_mis = !m_ovf;
        end
      end
      if (e_mis) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (CRASH_EN && en_crash_i) m_crash = 1;
      end
      if (call) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1;
        end
        q.push_back(cl);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    call_valid_i = 0; call_link_i = 0; ret_valid_i = 0; ret_link_i = 0; clear_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    en_crash_i = 0;
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #4 rst_ni = 1;
    model_reset();
    @(posedge clk_i); #1;
    n_cmp += 7;
    if (ret_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_ret_pc: got %h want 0", ret_pc_o); end
    if (ret_pc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ret_pc_valid_o); end
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL reset_mismatch: got %b want 0", mismatch_o); end
    if (to_crash_o !== 1'b0) begin n_err++; $display("FAIL reset_crash: got %b want 0", to_crash_o); end
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    if (depth_o !== 4'd0) begin n_err++; $display("FAIL reset_depth: got %0d want 0", depth_o); end
    if (mismatch_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", mismatch_cnt_o); end
  endtask

  task automatic test_match();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h73fa07c6, 0, 0, 0);
    cycle(0, 0, 1, 32'h73fa07c6, 0);
    n_cmp += 3;
    if (ret_pc_o !== 32'h80000104) begin n_err++; $display("FAIL match_ret_pc: got %h want 80000104", ret_pc_o); end
    if (ret_pc_valid_o !== 1'b1) begin n_err++; $display("FAIL match_valid: got %b want 1", ret_pc_valid_o); end
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL match_mismatch: got %b want 0", mismatch_o); end
    cycle(0, 0, 0, 0, 0);
    n_cmp += 2;
    if (ret_pc_valid_o !== 1'b0) begin n_err++; $display("FAIL match_valid_drop: got %b want 0", ret_pc_valid_o); end
    if (ret_pc_o !== 32'h0) begin n_err++; $display("FAIL match_pc_drop: got %h want 0", ret_pc_o); end
  endtask

  task automatic test_mismatch();
    logic want_crash;
    want_crash = CRASH_EN;
    en_crash_i = 1;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h73fa07c6, 0, 0, 0);
    cycle(0, 0, 1, 32'h73fa07ca, 0);
    n_cmp += 3;
    if (mismatch_o !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", mismatch_o); end
    if (mismatch_cnt_o !== 16'd1) begin n_err++; $display("FAIL mis_cnt: got %0d want 1", mismatch_cnt_o); end
    if (to_crash_o !== want_crash) begin n_err++; $display("FAIL mis_crash: got %b want %b", to_crash_o, want_crash); end
    cycle(0, 0, 0, 0, 0);
    n_cmp += 2;
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL mis_pulse_end: got %b want 0", mismatch_o); end
    if (to_crash_o !== want_crash) begin n_err++; $display("FAIL mis_crash_sticky: got %b want %b", to_crash_o, want_crash); end
    // Bits 0 and 31 of the return link do not take part in the compare.
    cycle(1, 32'h73fa07c6, 0, 0, 0);
    cycle(0, 0, 1, 32'hf3fa07c7, 0);
    n_cmp += 1;
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL mis_ignored_bits: got %b want 0", mismatch_o); end
    cycle(0, 0, 0, 0, 1);
    en_crash_i = 0;
    n_cmp += 2;
    if (to_crash_o !== 1'b0) begin n_err++; $display("FAIL clear_crash: got %b want 0", to_crash_o); end
    if (mismatch_cnt_o !== 16'd0) begin n_err++; $display("FAIL clear_cnt: got %0d want 0", mismatch_cnt_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] want_pc;
    cycle(0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) cycle(1, 32'h0000_1000 + 32'(i * 8), 0, 0, 0);
    n_cmp += 2;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
    if (depth_o !== 4'd8) begin n_err++; $display("FAIL ovf_depth: got %0d want 8", depth_o); end
    for (int i = 9; i >= 1; i--) begin
      cycle(0, 0, 1, 32'h0000_1000 + 32'(i * 8), 0);
      if (i >= 2) begin
        want_pc = {1'b1, (31'h1000 + 31'(i * 8)) ^ KEY};
        n_cmp += 3;
        if (ret_pc_valid_o !== 1'b1) begin n_err++; $display("FAIL ovf_pop_valid[%0d]: got %b want 1", i, ret_pc_valid_o); end
        if (ret_pc_o !== want_pc) begin n_err++; $display("FAIL ovf_pop_pc[%0d]: got %h want %h", i, ret_pc_o, want_pc); end
        if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL ovf_pop_mis[%0d]: got %b want 0", i, mismatch_o); end
      end else begin
        n_cmp += 3;
        if (ret_pc_valid_o !== 1'b0) begin n_err++; $display("FAIL ovf_silent_valid: got %b want 0", ret_pc_valid_o); end
        if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL ovf_silent_mis: got %b want 0", mismatch_o); end
        if (depth_o !== 4'd0) begin n_err++; $display("FAIL ovf_final_depth: got %0d want 0", depth_o); end
      end
    end
  endtask

  task automatic test_empty_return();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h1234_5678, 0);
    n_cmp += 3;
    if (mismatch_o !== 1'b1) begin n_err++; $display("FAIL empty_mis: got %b want 1", mismatch_o); end
    if (depth_o !== 4'd0) begin n_err++; $display("FAIL empty_depth: got %0d want 0", depth_o); end
    if (ret_pc_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b want 0", ret_pc_valid_o); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] want_pc;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h0a0a_0a0a, 0, 0, 0);
    cycle(1, 32'h0b0b_0b0b, 0, 0, 0);
    cycle(1, 32'h0c0c_0c0c, 0, 0, 0);
    cycle(1, 32'h1111_1111, 1, 32'h0c0c_0c0c, 0);
    want_pc = {1'b1, 31'h0c0c_0c0c ^ KEY};
    n_cmp += 3;
    if (depth_o !== 4'd3) begin n_err++; $display("FAIL simul_depth: got %0d want 3", depth_o); end
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL simul_mis: got %b want 0", mismatch_o); end
    if (ret_pc_o !== want_pc) begin n_err++; $display("FAIL simul_pc: got %h want %h", ret_pc_o, want_pc); end
    cycle(0, 0, 1, 32'h1111_1111, 0);
    want_pc = {1'b1, 31'h1111_1111 ^ KEY};
    n_cmp += 3;
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL simul_next_mis: got %b want 0", mismatch_o); end
    if (ret_pc_o !== want_pc) begin n_err++; $display("FAIL simul_next_pc: got %h want %h", ret_pc_o, want_pc); end
    if (depth_o !== 4'd2) begin n_err++; $display("FAIL simul_next_depth: got %0d want 2", depth_o); end
  endtask

  task automatic test_reset_mid();
    logic want_crash;
    want_crash = CRASH_EN;
    en_crash_i = 1;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 32'h2000_0000 + 32'(i * 4), 0, 0, 0);
    cycle(0, 0, 1, 32'h5555_5554, 0);
    idle_inputs();
    n_cmp += 2;
    if (depth_o !== 4'd5) begin n_err++; $display("FAIL mid_pre_depth: got %0d want 5", depth_o); end
    if (to_crash_o !== want_crash) begin n_err++; $display("FAIL mid_pre_crash: got %b want %b", to_crash_o, want_crash); end
    #3 rst_ni = 0;
    #1;
    n_cmp += 7;
    if (ret_pc_o !== 32'h0) begin n_err++; $display("FAIL mid_ret_pc: got %h want 0", ret_pc_o); end
    if (ret_pc_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", ret_pc_valid_o); end
    if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL mid_mis: got %b want 0", mismatch_o); end
    if (to_crash_o !== 1'b0) begin n_err++; $display("FAIL mid_crash: got %b want 0", to_crash_o); end
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL mid_ovf: got %b want 0", overflow_o); end
    if (depth_o !== 4'd0) begin n_err++; $display("FAIL mid_depth: got %0d want 0", depth_o); end
    if (mismatch_cnt_o !== 16'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", mismatch_cnt_o); end
    @(posedge clk_i);
    #4 rst_ni = 1;
    model_reset();
    @(posedge clk_i); #1;
    n_cmp += 1;
    if (depth_o !== 4'd0) begin n_err++; $display("FAIL mid_post_depth: got %0d want 0", depth_o); end
    cycle(0, 0, 1, 32'h2000_0014, 0);
    n_cmp += 2;
    if (mismatch_o !== 1'b1) begin n_err++; $display("FAIL mid_first_ret_mis: got %b want 1", mismatch_o); end
    if (ret_pc_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_first_ret_valid: got %b want 0", ret_pc_valid_o); end
    en_crash_i = 0;
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic        c, r, clr;
    logic [31:0] cl, rl;
    for (int n = 0; n < 600; n++) begin
      c   = ($urandom_range(1) == 1);
      r   = ($urandom_range(2) != 0);
      clr = ($urandom_range(59) == 0);
      cl  = $urandom;
      rl  = $urandom;
      if (q.size() > 0 && $urandom_range(3) != 0)
        rl = q[$] ^ {$urandom_range(1) == 1, 30'h0, $urandom_range(1) == 1};
      en_crash_i = ($urandom_range(1) == 1);
      cycle(c, cl, r, rl, clr);
      n_cmp += 7;
      if (ret_pc_o !== e_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, ret_pc_o, e_pc); end
      if (ret_pc_valid_o !== e_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ret_pc_valid_o, e_valid); end
      if (mismatch_o !== e_mis) begin n_err++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, mismatch_o, e_mis); end
      if (to_crash_o !== m_crash) begin n_err++; $display("FAIL rnd_crash[%0d]: got %b want %b", n, to_crash_o, m_crash); end
      if (overflow_o !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, overflow_o, m_ovf); end
      if (depth_o !== 4'(q.size())) begin n_err++; $display("FAIL rnd_depth[%0d]: got %0d want %0d", n, depth_o, q.size()); end
      if (mismatch_cnt_o !== m_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, mismatch_cnt_o, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_empty_return();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ra_guard_stack.md
RA_GUARD_STACK -- requirements
Module: ra_guard_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning shadow stack entries (power of two, 2..64).
REQ-002 SHALL have parameter KEY, default 31'h73fa06c2, meaning the link-encoding XOR key.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port call_valid_i, input, 1, a call resolved: JAL or JALR with rd=1.
REQ-006 SHALL have port call_link_i, input, 32, the encoded link written to rd: {1'b0, next_pc[30:0]^KEY}.
REQ-007 SHALL have port ret_valid_i, input, 1, a return resolved: JALR with rd=0, rs1=1.
REQ-008 SHALL have port ret_link_i, input, 32, the encoded rs1 value used by the return.
REQ-009 SHALL have port clear_i, input, 1, synchronous stack and flag clear.
REQ-010 SHALL have port en_crash_i, input, 1, crash enable.
REQ-011 SHALL have port ret_pc_o, output, 32, the decoded expected return PC.
REQ-012 SHALL have port ret_pc_valid_o, output, 1, qualifies ret_pc_o.
REQ-013 SHALL have port mismatch_o, output, 1, a one-cycle mismatch pulse.
REQ-014 SHALL have port to_crash_o, output, 1, sticky crash request.
REQ-015 SHALL have port overflow_o, output, 1, sticky entry-loss flag.
REQ-016 SHALL have port depth_o, output, $clog2(DEPTH)+1, current occupancy.
REQ-017 SHALL have port mismatch_cnt_o, output, 16, saturating mismatch count.

Function
REQ-018 SHALL implement the stack as a circular buffer with a top pointer and an occupancy counter; no data reset is required.
REQ-019 SHALL push call_link_i on call_valid_i, incrementing the occupancy counter.
REQ-020 SHALL, on a push while full, overwrite the oldest entry, hold the occupancy counter at DEPTH, and set overflow_o.
REQ-021 SHALL, on ret_valid_i while not empty, pop the top entry and compare bits [30:1] of the entry with bits [30:1] of ret_link_i; bit 0 and bit 31 are ignored.
REQ-022 SHALL, on ret_valid_i while empty, flag a mismatch only if overflow_o=0; with overflow_o=1, no mismatch is flagged.
REQ-023 SHALL drive ret_pc_o = {1'b1, popped[30:0]^KEY} and ret_pc_valid_o=1 in the cycle after a pop; both outputs are 0 otherwise.
REQ-024 SHALL register mismatch_o: it is high exactly one cycle, the cycle after the failing return.
REQ-025 SHALL increment mismatch_cnt_o on each mismatch, saturating at 16'hFFFF.
REQ-026 SHALL, on a simultaneous call and return, perform the pop and compare first and then the push; occupancy is unchanged, and the top entry becomes call_link_i.
REQ-027 SHALL, on clear_i, set occupancy, overflow_o, to_crash_o, mismatch_cnt_o, mismatch_o and ret_pc_valid_o to 0; clear_i has priority over same-cycle call and return.
REQ-028 SHALL have no handshake backpressure; every event is accepted in the cycle presented.

Reset
REQ-029 SHALL, while rst_ni=0, asynchronously force ret_pc_o=0, ret_pc_valid_o=0, mismatch_o=0, to_crash_o=0, overflow_o=0, depth_o=0, mismatch_cnt_o=0, and the pointers to 0.
REQ-030 SHALL, on reset assertion mid-operation, discard all stacked entries; the first return after reset is treated as empty with overflow_o=0 (REQ-022).

Configuration
REQ-031 SHALL, with RA_GUARD_CRASH_EN defined, set to_crash_o the cycle after a mismatch when en_crash_i=1; to_crash_o stays high until clear_i or reset.
REQ-032 SHALL, with RA_GUARD_CRASH_EN undefined, tie to_crash_o to 0; mismatch_o and mismatch_cnt_o still operate.

Verification
REQ-033 SHALL cover: push call_link_i=32'h73fa07c6, then return with ret_link_i=32'h73fa07c6 -> next cycle ret_pc_o=32'h80000104, ret_pc_valid_o=1, mismatch_o=0.
REQ-034 SHALL cover: push 32'h73fa07c6, then return with 32'h73fa07ca -> mismatch_o pulse, mismatch_cnt_o=1, and to_crash_o=1 when en_crash_i=1 (macro defined).
REQ-035 SHALL cover: 9 pushes with DEPTH=8 -> overflow_o=1, depth_o=8; then 9 returns -> 8 compares, 9th silent, depth_o=0.
REQ-036 SHALL cover: empty stack, overflow_o=0, one return -> mismatch_o=1, depth_o stays 0.
REQ-037 SHALL cover: depth 3, simultaneous call 32'h11111111 and matching return -> depth_o=3, next return compares against 32'h11111111.
REQ-038 SHALL cover: rst_ni low for one cycle mid-sequence with depth 5 and to_crash_o=1 -> all outputs 0 immediately, depth_o=0 after release.
